// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for the 5-stage RV32 core. It also detects
// load-use hazards. It captures the decoded operands and the control bundle
// from the decode stage and presents them, registered, to EX. When a load in
// EX feeds the instruction in ID, it inserts exactly one bubble and holds
// PC and IF/ID for that cycle. Two saturating counters record the bubbles
// inserted and the flushes applied, for performance debug.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   Stall_i                      global memory stall; freezes ID/EX
//   Flush_i                      squash the instruction entering EX
//   RS1addr_i/RS2addr_i/RDaddr_i ID register addresses
//   RS1data_i/RS2data_i/Imm_i    ID operands
//   Funct_i                      {funct7, funct3}
//   ALUOp_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i
//                                control bundle from the decode control unit
//   NoOp_o                       force a bubble in the control unit
//   PCWrite_o, IFIDWrite_o       upstream write enables
//   EX_*                         registered copies of the ID fields
//   EX_Valid_o                   1 = real instruction in EX, 0 = bubble
//   BubbleCnt_o, FlushCnt_o      saturating performance counters
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              Stall_i,
  input  logic              Flush_i,
  input  logic [REG_W-1:0]  RS1addr_i,
  input  logic [REG_W-1:0]  RS2addr_i,
  input  logic [REG_W-1:0]  RDaddr_i,
  input  logic [DATA_W-1:0] RS1data_i,
  input  logic [DATA_W-1:0] RS2data_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic [9:0]        Funct_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              ALUSrc_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  output logic              NoOp_o,
  output logic              PCWrite_o,
  output logic              IFIDWrite_o,
  output logic [1:0]        EX_ALUOp_o,
  output logic              EX_ALUSrc_o,
  output logic              EX_RegWrite_o,
  output logic              EX_MemtoReg_o,
  output logic              EX_MemRead_o,
  output logic              EX_MemWrite_o,
  output logic [DATA_W-1:0] EX_RS1data_o,
  output logic [DATA_W-1:0] EX_RS2data_o,
  output logic [DATA_W-1:0] EX_Imm_o,
  output logic [9:0]        EX_Funct_o,
  output logic [REG_W-1:0]  EX_RS1addr_o,
  output logic [REG_W-1:0]  EX_RS2addr_o,
  output logic [REG_W-1:0]  EX_RDaddr_o,
  output logic              EX_Valid_o,
  output logic [CNT_W-1:0]  BubbleCnt_o,
  output logic [CNT_W-1:0]  FlushCnt_o
);

  logic hazard;
  logic load_bubble;
  logic count_bubble;

  // Load in EX whose destination is read by the instruction in ID. A write
  // to x0 is discarded by the register file, so it can never create a hazard.
  always_comb begin
    hazard = EX_MemRead_o && (EX_RDaddr_o != '0) &&
             ((EX_RDaddr_o == RS1addr_i) || (EX_RDaddr_o == RS2addr_i));
  end

  assign NoOp_o      = hazard;
  assign PCWrite_o   = ~hazard & ~Stall_i;
  assign IFIDWrite_o = ~hazard & ~Stall_i;

  // A flush overrides a stall. A hazard bubble waits for the first edge
  // that is not stalled. NoOp_o stays asserted meanwhile because EX holds.
  assign load_bubble  = Flush_i | (~Stall_i & hazard);
  assign count_bubble = ~Flush_i & ~Stall_i & hazard;

  // NOTE: asynchronous active-low reset clears state at once with no clock.
  // Every sequential block below assigns only with non-blocking (<=)
  // assignments, so all registers update together at the edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      EX_ALUOp_o    <= '0;
      EX_ALUSrc_o   <= 1'b0;
      EX_RegWrite_o <= 1'b0;
      EX_MemtoReg_o <= 1'b0;
      EX_MemRead_o  <= 1'b0;
      EX_MemWrite_o <= 1'b0;
      EX_RS1data_o  <= '0;
      EX_RS2data_o  <= '0;
      EX_Imm_o      <= '0;
      EX_Funct_o    <= '0;
      EX_RS1addr_o  <= '0;
      EX_RS2addr_o  <= '0;
      EX_RDaddr_o   <= '0;
      EX_Valid_o    <= 1'b0;
    end else if (load_bubble) begin
      EX_ALUOp_o    <= '0;
      EX_ALUSrc_o   <= 1'b0;
      EX_RegWrite_o <= 1'b0;
      EX_MemtoReg_o <= 1'b0;
      EX_MemRead_o  <= 1'b0;
      EX_MemWrite_o <= 1'b0;
      EX_RS1data_o  <= '0;
      EX_RS2data_o  <= '0;
      EX_Imm_o      <= '0;
      EX_Funct_o    <= '0;
      EX_RS1addr_o  <= '0;
      EX_RS2addr_o  <= '0;
      EX_RDaddr_o   <= '0;
      EX_Valid_o    <= 1'b0;
    end else if (!Stall_i) begin
      EX_ALUOp_o    <= ALUOp_i;
      EX_ALUSrc_o   <= ALUSrc_i;
      EX_RegWrite_o <= RegWrite_i;
      EX_MemtoReg_o <= MemtoReg_i;
      EX_MemRead_o  <= MemRead_i;
      EX_MemWrite_o <= MemWrite_i;
      EX_RS1data_o  <= RS1data_i;
      EX_RS2data_o  <= RS2data_i;
      EX_Imm_o      <= Imm_i;
      EX_Funct_o    <= Funct_i;
      EX_RS1addr_o  <= RS1addr_i;
      EX_RS2addr_o  <= RS2addr_i;
      EX_RDaddr_o   <= RDaddr_i;
      EX_Valid_o    <= 1'b1;
    end
  end

  // Both counters saturate at all-ones so long runs never read back as small.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      BubbleCnt_o <= '0;
      FlushCnt_o  <= '0;
    end else begin
      if (Flush_i && (FlushCnt_o != '1)) begin
        FlushCnt_o <= FlushCnt_o + CNT_W'(1);
      end
      if (count_bubble && (BubbleCnt_o != '1)) begin
        BubbleCnt_o <= BubbleCnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage, built with CNT_W = 4 so that counter
// saturation is reached quickly. A table of directed vectors walks through
// plain capture, load-use bubbles, x0 loads, flush against a hazard, and a
// stall against a hazard. Hand-written sequences then cover a 3-cycle stall
// holding a store, an asynchronous reset in mid-cycle, and saturation of
// both counters.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              Stall_i = 1'b0;
  logic              Flush_i = 1'b0;
  logic [REG_W-1:0]  RS1addr_i = '0;
  logic [REG_W-1:0]  RS2addr_i = '0;
  logic [REG_W-1:0]  RDaddr_i = '0;
  logic [DATA_W-1:0] RS1data_i = '0;
  logic [DATA_W-1:0] RS2data_i = '0;
  logic [DATA_W-1:0] Imm_i = '0;
  logic [9:0]        Funct_i = '0;
  logic [1:0]        ALUOp_i = '0;
  logic              ALUSrc_i = 1'b0;
  logic              RegWrite_i = 1'b0;
  logic              MemtoReg_i = 1'b0;
  logic              MemRead_i = 1'b0;
  logic              MemWrite_i = 1'b0;
  logic              NoOp_o;
  logic              PCWrite_o;
  logic              IFIDWrite_o;
  logic [1:0]        EX_ALUOp_o;
  logic              EX_ALUSrc_o;
  logic              EX_RegWrite_o;
  logic              EX_MemtoReg_o;
  logic              EX_MemRead_o;
  logic              EX_MemWrite_o;
  logic [DATA_W-1:0] EX_RS1data_o;
  logic [DATA_W-1:0] EX_RS2data_o;
  logic [DATA_W-1:0] EX_Imm_o;
  logic [9:0]        EX_Funct_o;
  logic [REG_W-1:0]  EX_RS1addr_o;
  logic [REG_W-1:0]  EX_RS2addr_o;
  logic [REG_W-1:0]  EX_RDaddr_o;
  logic              EX_Valid_o;
  logic [CNT_W-1:0]  BubbleCnt_o;
  logic [CNT_W-1:0]  FlushCnt_o;

  int checks   = 0;
  int failures = 0;

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .Stall_i(Stall_i), .Flush_i(Flush_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i),
    .Funct_i(Funct_i), .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .NoOp_o(NoOp_o), .PCWrite_o(PCWrite_o),
    .IFIDWrite_o(IFIDWrite_o), .EX_ALUOp_o(EX_ALUOp_o),
    .EX_ALUSrc_o(EX_ALUSrc_o), .EX_RegWrite_o(EX_RegWrite_o),
    .EX_MemtoReg_o(EX_MemtoReg_o), .EX_MemRead_o(EX_MemRead_o),
    .EX_MemWrite_o(EX_MemWrite_o), .EX_RS1data_o(EX_RS1data_o),
    .EX_RS2data_o(EX_RS2data_o), .EX_Imm_o(EX_Imm_o), .EX_Funct_o(EX_Funct_o),
    .EX_RS1addr_o(EX_RS1addr_o), .EX_RS2addr_o(EX_RS2addr_o),
    .EX_RDaddr_o(EX_RDaddr_o), .EX_Valid_o(EX_Valid_o),
    .BubbleCnt_o(BubbleCnt_o), .FlushCnt_o(FlushCnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int flush, input int stall, input int rs1,
                        input int rs2, input int rd, input int mr,
                        input int mw, input int rw, input int aluop,
                        input int alusrc, input int m2r,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input int funct);
    Flush_i    = 1'(flush);
    Stall_i    = 1'(stall);
    RS1addr_i  = 5'(rs1);
    RS2addr_i  = 5'(rs2);
    RDaddr_i   = 5'(rd);
    MemRead_i  = 1'(mr);
    MemWrite_i = 1'(mw);
    RegWrite_i = 1'(rw);
    ALUOp_i    = 2'(aluop);
    ALUSrc_i   = 1'(alusrc);
    MemtoReg_i = 1'(m2r);
    RS1data_i  = d1;
    RS2data_i  = d2;
    Imm_i      = imm;
    Funct_i    = 10'(funct);
  endtask

  // One table row: ID-side inputs, upstream outputs expected before the
  // edge, and EX-side state expected after the edge.
  typedef struct {
    int flush, stall, rs1, rs2, rd, mr, rw, aluop, d1;
    int e_noop, e_pcw;
    int e_valid, e_rd, e_mr, e_rw, e_aluop, e_d1, e_b, e_f;
  } vec_t;

  vec_t vecs[14];

  initial begin
    //            fl st rs1 rs2 rd mr rw op  d1     noop pcw  v rd mr rw op d1     b  f
    vecs[0]  = '{0, 0,  1,  2,  3, 0, 1, 2, 'h11,  0, 1,  1,  3, 0, 1, 2, 'h11, 0, 0};
    vecs[1]  = '{0, 0,  1,  0,  5, 1, 1, 0, 'h22,  0, 1,  1,  5, 1, 1, 0, 'h22, 0, 0};
    vecs[2]  = '{0, 0,  5,  2,  6, 0, 1, 2, 'h33,  1, 0,  0,  0, 0, 0, 0, 0,    1, 0};
    vecs[3]  = '{0, 0,  5,  2,  6, 0, 1, 2, 'h33,  0, 1,  1,  6, 0, 1, 2, 'h33, 1, 0};
    vecs[4]  = '{0, 0,  1,  0,  0, 1, 1, 0, 'h44,  0, 1,  1,  0, 1, 1, 0, 'h44, 1, 0};
    vecs[5]  = '{0, 0,  7,  0,  8, 0, 1, 2, 'h55,  0, 1,  1,  8, 0, 1, 2, 'h55, 1, 0};
    vecs[6]  = '{0, 0,  1,  0,  9, 1, 1, 0, 'h66,  0, 1,  1,  9, 1, 1, 0, 'h66, 1, 0};
    vecs[7]  = '{1, 0,  4,  9, 10, 0, 1, 2, 'h77,  1, 0,  0,  0, 0, 0, 0, 0,    1, 1};
    vecs[8]  = '{0, 0,  4,  9, 10, 0, 1, 2, 'h77,  0, 1,  1, 10, 0, 1, 2, 'h77, 1, 1};
    vecs[9]  = '{0, 0,  1,  0, 11, 1, 1, 0, 'h88,  0, 1,  1, 11, 1, 1, 0, 'h88, 1, 1};
    vecs[10] = '{0, 1, 11,  3, 12, 0, 1, 2, 'h99,  1, 0,  1, 11, 1, 1, 0, 'h88, 1, 1};
    vecs[11] = '{0, 0, 11,  3, 12, 0, 1, 2, 'h99,  1, 0,  0,  0, 0, 0, 0, 0,    2, 1};
    vecs[12] = '{0, 0, 11,  3, 12, 0, 1, 2, 'h99,  0, 1,  1, 12, 0, 1, 2, 'h99, 2, 1};
    vecs[13] = '{0, 1,  0,  0, 13, 0, 1, 2, 'hAA,  0, 0,  1, 12, 0, 1, 2, 'h99, 2, 1};

    // Reset, asserted away from any edge.
    #2 rst_i = 1'b0;
    #1;
    check("rst_valid", 32'(EX_Valid_o), 0);
    check("rst_regwrite", 32'(EX_RegWrite_o), 0);
    check("rst_memread", 32'(EX_MemRead_o), 0);
    check("rst_rs1data", EX_RS1data_o, 0);
    check("rst_bubble_cnt", 32'(BubbleCnt_o), 0);
    check("rst_flush_cnt", 32'(FlushCnt_o), 0);
    check("rst_noop", 32'(NoOp_o), 0);
    check("rst_pcwrite", 32'(PCWrite_o), 1);
    check("rst_ifidwrite", 32'(IFIDWrite_o), 1);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk_i);
      set_in(vecs[i].flush, vecs[i].stall, vecs[i].rs1, vecs[i].rs2,
             vecs[i].rd, vecs[i].mr, 0, vecs[i].rw, vecs[i].aluop,
             vecs[i].mr, vecs[i].mr, vecs[i].d1, vecs[i].d1 ^ 32'hFFFF0000,
             vecs[i].d1 + 1, vecs[i].d1);
      #1;
      check($sformatf("v%0d_noop", i), 32'(NoOp_o), vecs[i].e_noop);
      check($sformatf("v%0d_pcwrite", i), 32'(PCWrite_o), vecs[i].e_pcw);
      check($sformatf("v%0d_ifidwrite", i), 32'(IFIDWrite_o), vecs[i].e_pcw);
      @(posedge clk_i);
      #1;
      check($sformatf("v%0d_valid", i), 32'(EX_Valid_o), vecs[i].e_valid);
      check($sformatf("v%0d_rd", i), 32'(EX_RDaddr_o), vecs[i].e_rd);
      check($sformatf("v%0d_memread", i), 32'(EX_MemRead_o), vecs[i].e_mr);
      check($sformatf("v%0d_regwrite", i), 32'(EX_RegWrite_o), vecs[i].e_rw);
      check($sformatf("v%0d_aluop", i), 32'(EX_ALUOp_o), vecs[i].e_aluop);
      check($sformatf("v%0d_rs1data", i), EX_RS1data_o, vecs[i].e_d1);
      check($sformatf("v%0d_bubble_cnt", i), 32'(BubbleCnt_o), vecs[i].e_b);
      check($sformatf("v%0d_flush_cnt", i), 32'(FlushCnt_o), vecs[i].e_f);
    end

    // sw x3, 16(x2) captured, then held across three stalled cycles.
    @(negedge clk_i);
    set_in(0, 0, 2, 3, 0, 0, 1, 0, 0, 1, 0, 32'hAB, 32'hCD, 32'h10, 2);
    @(posedge clk_i);
    #1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(negedge clk_i);
        set_in(0, 1, 6, 7, 8, 0, 0, 1, 2, 0, 0, 32'h5A5A, 32'hA5A5, 32'h7, 'h100);
        #1;
        check($sformatf("sw_c%0d_pcwrite", c), 32'(PCWrite_o), 0);
        check($sformatf("sw_c%0d_ifidwrite", c), 32'(IFIDWrite_o), 0);
        @(posedge clk_i);
        #1;
      end
      check($sformatf("sw_c%0d_valid", c), 32'(EX_Valid_o), 1);
      check($sformatf("sw_c%0d_memwrite", c), 32'(EX_MemWrite_o), 1);
      check($sformatf("sw_c%0d_alusrc", c), 32'(EX_ALUSrc_o), 1);
      check($sformatf("sw_c%0d_regwrite", c), 32'(EX_RegWrite_o), 0);
      check($sformatf("sw_c%0d_memtoreg", c), 32'(EX_MemtoReg_o), 0);
      check($sformatf("sw_c%0d_rs1data", c), EX_RS1data_o, 32'hAB);
      check($sformatf("sw_c%0d_rs2data", c), EX_RS2data_o, 32'hCD);
      check($sformatf("sw_c%0d_imm", c), EX_Imm_o, 32'h10);
      check($sformatf("sw_c%0d_funct", c), 32'(EX_Funct_o), 2);
      check($sformatf("sw_c%0d_rs1addr", c), 32'(EX_RS1addr_o), 2);
      check($sformatf("sw_c%0d_rs2addr", c), 32'(EX_RS2addr_o), 3);
      check($sformatf("sw_c%0d_rd", c), 32'(EX_RDaddr_o), 0);
    end
    // Release: the next ID instruction (a load) is captured on one edge.
    @(negedge clk_i);
    set_in(0, 0, 6, 7, 8, 1, 0, 1, 0, 1, 1, 32'h5A5A, 32'hA5A5, 32'h7, 'h100);
    #1;
    check("rel_pcwrite", 32'(PCWrite_o), 1);
    @(posedge clk_i);
    #1;
    check("rel_rd", 32'(EX_RDaddr_o), 8);
    check("rel_memtoreg", 32'(EX_MemtoReg_o), 1);
    check("rel_memwrite", 32'(EX_MemWrite_o), 0);
    check("rel_rs2data", EX_RS2data_o, 32'hA5A5);
    check("rel_funct", 32'(EX_Funct_o), 'h100);
    check("rel_rs2addr", 32'(EX_RS2addr_o), 7);

    // Asynchronous reset between edges clears everything with no clock.
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("arst_valid", 32'(EX_Valid_o), 0);
    check("arst_memread", 32'(EX_MemRead_o), 0);
    check("arst_rd", 32'(EX_RDaddr_o), 0);
    check("arst_imm", EX_Imm_o, 0);
    check("arst_bubble_cnt", 32'(BubbleCnt_o), 0);
    check("arst_flush_cnt", 32'(FlushCnt_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Bubble counter saturation: 17 load-use pairs with a 4-bit counter.
    for (int k = 0; k < 17; k++) begin
      @(negedge clk_i);
      set_in(0, 0, 1, 0, 5, 1, 0, 1, 0, 1, 1, 32'h1, 32'h2, 32'h3, 0);
      @(posedge clk_i);
      @(negedge clk_i);
      set_in(0, 0, 5, 2, 6, 0, 0, 1, 2, 0, 0, 32'h4, 32'h5, 32'h6, 0);
      #1;
      check($sformatf("sat_b%0d_noop", k), 32'(NoOp_o), 1);
      @(posedge clk_i);
      #1;
      if (k == 14) check("sat_bubble_15", 32'(BubbleCnt_o), 15);
      if (k == 16) check("sat_bubble_hold", 32'(BubbleCnt_o), 15);
    end

    // Flush counter saturation: 17 consecutive flushes.
    for (int k = 0; k < 17; k++) begin
      @(negedge clk_i);
      set_in(1, 0, 1, 2, 3, 0, 0, 1, 2, 0, 0, 32'h9, 32'h9, 32'h9, 0);
      @(posedge clk_i);
      #1;
      if (k == 0) check("sat_f0_valid", 32'(EX_Valid_o), 0);
      if (k == 14) check("sat_flush_15", 32'(FlushCnt_o), 15);
      if (k == 16) check("sat_flush_hold", 32'(FlushCnt_o), 15);
    end
    check("sat_bubble_untouched", 32'(BubbleCnt_o), 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
